// File: rtl/gb_ppu_timing_ctrl.sv
// DMG PPU scanline/frame sequencer: dot/line counters, mode FSM, interrupts and CPU access locks.
// Optional LY153_EARLY_WRAP_EN: on line 153 the visible LY reads 0 from dot 4 onward.
module gb_ppu_timing_ctrl #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154,
    parameter int VISIBLE_LINES   = 144,
    parameter int OAM_SCAN_DOTS   = 80,
    parameter int MIN_DRAW_DOTS   = 172,
    parameter int MAX_DRAW_DOTS   = 289
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_src_en,
    input  logic       draw_done,
    output logic [1:0] ppu_mode,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic       lyc_match,
    output logic       oam_locked,
    output logic       vram_locked,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       frame_start
);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_OAM_SCAN,
        ST_DRAWING,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    localparam logic [8:0] LAST_DOT      = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LAST_LINE     = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] FIRST_VBLANK  = 8'(VISIBLE_LINES);
    localparam logic [8:0] OAM_DOTS      = 9'(OAM_SCAN_DOTS);
    localparam logic [8:0] OAM_LAST_DOT  = 9'(OAM_SCAN_DOTS - 1);
    localparam logic [8:0] DRAW_MIN_LAST = 9'(MIN_DRAW_DOTS - 1);
    localparam logic [8:0] DRAW_MAX_LAST = 9'(MAX_DRAW_DOTS - 1);

`ifdef LY153_EARLY_WRAP_EN
    localparam logic EARLY_WRAP = 1'b1;
`else
    localparam logic EARLY_WRAP = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] line_q, line_d;
    logic       draw_latch_q, draw_latch_d;
    logic       stat_line_q, stat_line_d;
    logic       stat_irq_q, stat_irq_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       frame_start_q, frame_start_d;
    logic       line_wrap;
    logic [8:0] elapsed;
    logic [1:0] next_mode;
    logic [7:0] next_ly;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            ST_OAM_SCAN: return 2'd2;
            ST_DRAWING:  return 2'd3;
            ST_VBLANK:   return 2'd1;
            default:     return 2'd0;
        endcase
    endfunction

    // Visible LY; the internal line counter is never altered by the early wrap.
    function automatic logic [7:0] ly_view(input logic [7:0] line, input logic [8:0] d);
        if (EARLY_WRAP && line == LAST_LINE && d >= 9'd4) return 8'd0;
        return line;
    endfunction

    always_comb begin
        state_d       = state_q;
        dot_d         = dot_q;
        line_d        = line_q;
        draw_latch_d  = 1'b0;
        vblank_irq_d  = 1'b0;
        frame_start_d = 1'b0;
        line_wrap     = (dot_q == LAST_DOT);
        elapsed       = dot_q - OAM_DOTS;

        if (state_q == ST_DISABLED) begin
            dot_d  = 9'd0;
            line_d = 8'd0;
            if (lcd_en) begin
                state_d       = ST_OAM_SCAN;
                frame_start_d = 1'b1;
            end
        end else if (!lcd_en) begin
            state_d = ST_DISABLED;
            dot_d   = 9'd0;
            line_d  = 8'd0;
        end else begin
            if (line_wrap) begin
                dot_d  = 9'd0;
                line_d = (line_q == LAST_LINE) ? 8'd0 : line_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
            frame_start_d = line_wrap && (line_q == LAST_LINE);

            case (state_q)
                ST_OAM_SCAN: begin
                    if (dot_q == OAM_LAST_DOT) state_d = ST_DRAWING;
                end
                ST_DRAWING: begin
                    // A draw_done pulse seen before the minimum length is held until it can act.
                    draw_latch_d = draw_latch_q | draw_done;
                    if ((draw_latch_d && elapsed >= DRAW_MIN_LAST) || elapsed == DRAW_MAX_LAST) begin
                        state_d      = ST_HBLANK;
                        draw_latch_d = 1'b0;
                    end
                end
                ST_HBLANK: begin
                    if (line_wrap) begin
                        if (line_d < FIRST_VBLANK) begin
                            state_d = ST_OAM_SCAN;
                        end else begin
                            state_d      = ST_VBLANK;
                            vblank_irq_d = 1'b1;
                        end
                    end
                end
                ST_VBLANK: begin
                    if (line_wrap && line_d == 8'd0) state_d = ST_OAM_SCAN;
                end
                default: state_d = ST_DISABLED;
            endcase
        end

        // STAT line is evaluated against the state being entered so the pulse lines up with it.
        next_mode   = mode_of(state_d);
        next_ly     = ly_view(line_d, dot_d);
        stat_line_d = (state_d != ST_DISABLED) &&
                      ((stat_src_en[3] && next_ly == lyc) ||
                       (stat_src_en[2] && next_mode == 2'd2) ||
                       (stat_src_en[1] && next_mode == 2'd1) ||
                       (stat_src_en[0] && next_mode == 2'd0));
        stat_irq_d  = stat_line_d && !stat_line_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_DISABLED;
            dot_q         <= 9'd0;
            line_q        <= 8'd0;
            draw_latch_q  <= 1'b0;
            stat_line_q   <= 1'b0;
            stat_irq_q    <= 1'b0;
            vblank_irq_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dot_q         <= dot_d;
            line_q        <= line_d;
            draw_latch_q  <= draw_latch_d;
            stat_line_q   <= stat_line_d;
            stat_irq_q    <= stat_irq_d;
            vblank_irq_q  <= vblank_irq_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ppu_mode    = mode_of(state_q);
    assign ly          = ly_view(line_q, dot_q);
    assign dot         = dot_q;
    assign lyc_match   = (ly == lyc);
    assign oam_locked  = (state_q == ST_OAM_SCAN) || (state_q == ST_DRAWING);
    assign vram_locked = (state_q == ST_DRAWING);
    assign vblank_irq  = vblank_irq_q;
    assign stat_irq    = stat_irq_q;
    assign frame_start = frame_start_q;

endmodule
